// File: rtl/packer_output_register.sv
`default_nettype none
// ============================================================================
// Module      : packer_output_register
// Description : Half-buffer output stage for the word packer. Holds one
//               packed word (data, lane mask, last) with a valid flag and
//               reports whether it can take a new word this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module packer_output_register #(
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [MASK_WIDTH-1:0] load_mask,
  input  logic                  load_last,
  input  logic                  ready_out,
  output logic                  can_load,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [MASK_WIDTH-1:0] mask_out,
  output logic                  last_out
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [MASK_WIDTH-1:0] mask_q, mask_d;
  logic                  last_q, last_d;

  // Empty, or the current word leaves this cycle: either way a new one fits.
  assign can_load = ~valid_q | ready_out;

  // Next-state: load a new word, otherwise drop valid once accepted; hold payload.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    mask_d  = mask_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      mask_d  = load_mask;
      last_d  = load_last;
    end else if (ready_out) begin
      valid_d = 1'b0;
    end
  end

  // Output register with asynchronous clear.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign mask_out  = mask_q;
  assign last_out  = last_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_word_packer
// Description : Packs WORD_COUNT narrow ready/valid words into one wide
//               ready/valid word, lane 0 first. last_in flushes a partial
//               word with a lane-valid mask.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_word_packer #(
  parameter int WORD_WIDTH_IN = 8,
  parameter int WORD_COUNT    = 4
) (
  input  logic                                clock,
  input  logic                                clear,
  input  logic                                valid_in,
  output logic                                ready_in,
  input  logic [WORD_WIDTH_IN-1:0]            data_in,
  input  logic                                last_in,
  output logic                                valid_out,
  input  logic                                ready_out,
  output logic [WORD_WIDTH_IN*WORD_COUNT-1:0] data_out,
  output logic [WORD_COUNT-1:0]               lane_valid_out,
  output logic                                last_out
);

  localparam int OUTPUT_WIDTH = WORD_WIDTH_IN * WORD_COUNT;
  localparam int COUNT_WIDTH  = $clog2(WORD_COUNT);
  localparam logic [COUNT_WIDTH-1:0] LAST_LANE = COUNT_WIDTH'(WORD_COUNT - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  logic [OUTPUT_WIDTH-1:0] lanes_q, lanes_d;
  logic [WORD_COUNT-1:0]   mask_q, mask_d;
  logic                    last_q, last_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    complete_q, complete_d;

  logic output_can_load;
  logic handoff;
  logic accept;

  // A finished assembly moves out whenever the output stage has room; the
  // input stays open on that same cycle so lane 0 refills without a bubble.
  assign handoff  = complete_q & output_can_load;
  assign ready_in = ~complete_q | output_can_load;
  assign accept   = valid_in & ready_in;

  // Assembly next-state: clear on handoff, then write the accepted word.
  always_comb begin
    lanes_d    = lanes_q;
    mask_d     = mask_q;
    last_d     = last_q;
    count_d    = count_q;
    complete_d = complete_q;
    if (handoff) begin
      lanes_d    = '0;
      mask_d     = '0;
      last_d     = 1'b0;
      complete_d = 1'b0;
    end
    if (accept) begin
      lanes_d[int'(count_q)*WORD_WIDTH_IN +: WORD_WIDTH_IN] = data_in;
      mask_d[count_q] = 1'b1;
      if ((count_q == LAST_LANE) || last_in) begin
        complete_d = 1'b1;
        last_d     = last_in;
        count_d    = '0;
      end else begin
        count_d = count_q + COUNT_ONE;
      end
    end
  end

  // Assembly register with asynchronous clear.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      lanes_q    <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      count_q    <= '0;
      complete_q <= 1'b0;
    end else begin
      lanes_q    <= lanes_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      count_q    <= count_d;
      complete_q <= complete_d;
    end
  end

  packer_output_register #(
    .DATA_WIDTH (OUTPUT_WIDTH),
    .MASK_WIDTH (WORD_COUNT)
  ) u_output_register (
    .clock     (clock),
    .clear     (clear),
    .load      (handoff),
    .load_data (lanes_q),
    .load_mask (mask_q),
    .load_last (last_q),
    .ready_out (ready_out),
    .can_load  (output_can_load),
    .valid_out (valid_out),
    .data_out  (data_out),
    .mask_out  (lane_valid_out),
    .last_out  (last_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_word_packer
// Description : Self-checking bench for pipeline_word_packer (8-bit x 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_word_packer;

  logic        clock = 1'b0;
  logic        clear;
  logic        valid_in;
  logic        ready_in;
  logic [7:0]  data_in;
  logic        last_in;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] data_out;
  logic [3:0]  lane_valid_out;
  logic        last_out;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  m;
    logic        l;
  } pkt_t;

  pkt_t       exp_q[$];
  logic [7:0] cur_words[$];

  pipeline_word_packer #(.WORD_WIDTH_IN(8), .WORD_COUNT(4)) dut (
    .clock          (clock),
    .clear          (clear),
    .valid_in       (valid_in),
    .ready_in       (ready_in),
    .data_in        (data_in),
    .last_in        (last_in),
    .valid_out      (valid_out),
    .ready_out      (ready_out),
    .data_out       (data_out),
    .lane_valid_out (lane_valid_out),
    .last_out       (last_out)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic send_word(input logic [7:0] d, input logic l, output int stalls);
    int waited;
    stalls   = 0;
    valid_in = 1'b1;
    data_in  = d;
    last_in  = l;
    #1;
    waited = 0;
    while (!ready_in && waited < 50) begin
      step();
      waited++;
    end
    stalls = waited;
    if (!ready_in) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: ready_in=%0b required 1 for word %h", ready_in, d);
    end
    step();
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  // Wait (bounded) until valid_out is high at a sample point.
  task automatic wait_out(output logic got);
    int n;
    n = 0;
    while (!valid_out && n < 20) begin
      step();
      n++;
    end
    got = valid_out;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_out_timeout: valid_out=%0b required 1", valid_out);
    end
  endtask

  task automatic do_clear();
    @(posedge clock);
    #2 clear = 1'b1;
    #2 clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clear = 1'b1; valid_in = 1'b0; data_in = '0; last_in = 1'b0; ready_out = 1'b0;
    #3;
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b required 0", valid_out); end
    vectors++; if (data_out !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h required 00000000", data_out); end
    vectors++; if (lane_valid_out !== 4'b0) begin miscompares++; $display("FAIL reset_mask: got %b required 0000", lane_valid_out); end
    vectors++; if (last_out !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %0b required 0", last_out); end
    vectors++; if (ready_in !== 1'b1) begin miscompares++; $display("FAIL reset_ready_in: got %0b required 1", ready_in); end
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int s;
    ready_out = 1'b1;
    send_word(8'h11, 1'b0, s);
    send_word(8'h22, 1'b0, s);
    send_word(8'h33, 1'b0, s);
    send_word(8'h44, 1'b0, s);
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL basic_latency_early: valid_out %0b required 0", valid_out); end
    step();
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %0b required 1", valid_out); end
    vectors++; if (data_out !== 32'h44332211) begin miscompares++; $display("FAIL basic_data: got %h required 44332211", data_out); end
    vectors++; if (lane_valid_out !== 4'b1111) begin miscompares++; $display("FAIL basic_mask: got %b required 1111", lane_valid_out); end
    vectors++; if (last_out !== 1'b0) begin miscompares++; $display("FAIL basic_last: got %0b required 0", last_out); end
    step();
    vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL basic_one_cycle: valid_out %0b required 0", valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] seen[$];
    int          seen_t[$];
    int          total_stalls;
    do_clear();
    ready_out    = 1'b1;
    total_stalls = 0;
    fork
      begin
        int s;
        for (int i = 1; i <= 8; i++) begin
          send_word(8'((i << 4) | i), 1'b0, s);
          total_stalls += s;
        end
      end
      begin
        for (int c = 0; c < 14; c++) begin
          step();
          if (valid_out) begin seen.push_back(data_out); seen_t.push_back(c); end
        end
      end
    join
    vectors++; if (total_stalls != 0) begin miscompares++; $display("FAIL b2b_ready_in: stall cycles %0d required 0", total_stalls); end
    vectors++;
    if (seen.size() != 2) begin
      miscompares++; $display("FAIL b2b_count: got %0d outputs required 2", seen.size());
    end else begin
      if (seen[0] !== 32'h44332211 || seen[1] !== 32'h88776655) begin
        miscompares++; $display("FAIL b2b_data: got %h %h required 44332211 88776655", seen[0], seen[1]);
      end
      vectors++;
      if (seen_t[1] - seen_t[0] != 4) begin
        miscompares++; $display("FAIL b2b_spacing: got %0d cycles required 4", seen_t[1] - seen_t[0]);
      end
    end
  endtask

  task automatic test_last_partial();
    int   s;
    logic got;
    do_clear();
    ready_out = 1'b1;
    send_word(8'hAA, 1'b0, s);
    send_word(8'hBB, 1'b1, s);
    wait_out(got);
    vectors++; if (data_out !== 32'h0000BBAA) begin miscompares++; $display("FAIL partial_data: got %h required 0000BBAA", data_out); end
    vectors++; if (lane_valid_out !== 4'b0011) begin miscompares++; $display("FAIL partial_mask: got %b required 0011", lane_valid_out); end
    vectors++; if (last_out !== 1'b1) begin miscompares++; $display("FAIL partial_last: got %0b required 1", last_out); end
    send_word(8'hCC, 1'b0, s);
    send_word(8'hDD, 1'b0, s);
    send_word(8'hEE, 1'b0, s);
    send_word(8'hFF, 1'b0, s);
    wait_out(got);
    vectors++; if (data_out !== 32'hFFEEDDCC || last_out !== 1'b0) begin miscompares++; $display("FAIL partial_next: got %h last %0b required FFEEDDCC last 0", data_out, last_out); end
    // Single word closed by last lands alone in lane 0.
    step();
    send_word(8'h5A, 1'b1, s);
    wait_out(got);
    vectors++; if (data_out !== 32'h0000005A || lane_valid_out !== 4'b0001) begin miscompares++; $display("FAIL lane0_last: got %h/%b required 0000005A/0001", data_out, lane_valid_out); end
  endtask

  task automatic test_backpressure();
    int s;
    do_clear();
    ready_out = 1'b0;
    for (int i = 1; i <= 8; i++) send_word(8'((i << 4) | i), 1'b0, s);
    valid_in = 1'b1; data_in = 8'h99; last_in = 1'b0;
    #1;
    vectors++; if (ready_in !== 1'b0) begin miscompares++; $display("FAIL bp_ready_in: got %0b required 0", ready_in); end
    vectors++; if (valid_out !== 1'b1 || data_out !== 32'h44332211) begin miscompares++; $display("FAIL bp_first: got %0b/%h required 1/44332211", valid_out, data_out); end
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (ready_in !== 1'b0 || data_out !== 32'h44332211 || lane_valid_out !== 4'b1111) begin
        miscompares++; $display("FAIL bp_hold: ready_in %0b data %h mask %b required 0 44332211 1111", ready_in, data_out, lane_valid_out);
      end
    end
    ready_out = 1'b1;
    #1;
    vectors++; if (ready_in !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %0b required 1", ready_in); end
    step();
    valid_in = 1'b0;
    vectors++; if (valid_out !== 1'b1 || data_out !== 32'h88776655) begin miscompares++; $display("FAIL bp_second: got %0b/%h required 1/88776655", valid_out, data_out); end
    // Finish the packet started by 0x99 and confirm it took lane 0.
    send_word(8'hA0, 1'b1, s);
    step();
    vectors++; if (data_out !== 32'h0000A099 || lane_valid_out !== 4'b0011) begin miscompares++; $display("FAIL bp_ninth: got %h/%b required 0000A099/0011", data_out, lane_valid_out); end
  endtask

  task automatic test_clear_midway();
    int   s;
    logic got;
    do_clear();
    ready_out = 1'b0;
    for (int i = 1; i <= 6; i++) send_word(8'((i << 4) | i), 1'b0, s);
    vectors++; if (valid_out !== 1'b1) begin miscompares++; $display("FAIL clr_pre_valid: got %0b required 1", valid_out); end
    #2 clear = 1'b1;
    #1;
    vectors++; if (valid_out !== 1'b0 || ready_in !== 1'b1 || lane_valid_out !== 4'b0) begin miscompares++; $display("FAIL clr_async: valid %0b ready_in %0b mask %b required 0 1 0000", valid_out, ready_in, lane_valid_out); end
    #1 clear = 1'b0;
    step();
    ready_out = 1'b1;
    for (int i = 5; i <= 8; i++) send_word(8'((i << 4) | i), 1'b0, s);
    wait_out(got);
    vectors++; if (data_out !== 32'h88776655 || lane_valid_out !== 4'b1111) begin miscompares++; $display("FAIL clr_after: got %h/%b required 88776655/1111", data_out, lane_valid_out); end
  endtask

  task automatic test_last_ignored();
    int   s;
    logic got;
    int   spurious;
    do_clear();
    ready_out = 1'b1;
    valid_in  = 1'b0;
    last_in   = 1'b1;
    data_in   = 8'hEE;
    spurious  = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (valid_out) spurious++;
    end
    last_in = 1'b0;
    vectors++; if (spurious != 0) begin miscompares++; $display("FAIL last_idle: valid_out cycles %0d required 0", spurious); end
    send_word(8'h01, 1'b0, s);
    send_word(8'h02, 1'b0, s);
    send_word(8'h03, 1'b0, s);
    send_word(8'h04, 1'b1, s);
    wait_out(got);
    vectors++; if (data_out !== 32'h04030201 || lane_valid_out !== 4'b1111 || last_out !== 1'b1) begin miscompares++; $display("FAIL last_full: got %h/%b/%0b required 04030201/1111/1", data_out, lane_valid_out, last_out); end
  endtask

  // Reference model: accumulate accepted words, emit a packed word on the
  // fourth word or on last; compare against every output handshake.
  task automatic test_random();
    pkt_t        e;
    logic        prev_stall;
    logic [31:0] prev_d;
    logic [3:0]  prev_m;
    logic        prev_l;
    do_clear();
    exp_q.delete();
    cur_words.delete();
    prev_stall = 1'b0;
    prev_d = '0; prev_m = '0; prev_l = 1'b0;
    for (int i = 0; i < 460; i++) begin
      if (i < 400) begin
        valid_in  = ($urandom_range(0, 3) != 0);
        data_in   = 8'($urandom);
        last_in   = ($urandom_range(0, 4) == 0);
        ready_out = ($urandom_range(0, 2) != 0);
      end else begin
        valid_in  = 1'b0;
        last_in   = 1'b0;
        ready_out = 1'b1;
      end
      #1;
      if (prev_stall) begin
        vectors++;
        if (valid_out !== 1'b1 || data_out !== prev_d || lane_valid_out !== prev_m || last_out !== prev_l) begin
          miscompares++;
          $display("FAIL rand_hold: got %0b/%h/%b/%0b required 1/%h/%b/%0b", valid_out, data_out, lane_valid_out, last_out, prev_d, prev_m, prev_l);
        end
      end
      if (valid_out && ready_out) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_unexpected: got %h/%b/%0b required no output", data_out, lane_valid_out, last_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e.d || lane_valid_out !== e.m || last_out !== e.l) begin
            miscompares++;
            $display("FAIL rand_data: got %h/%b/%0b required %h/%b/%0b", data_out, lane_valid_out, last_out, e.d, e.m, e.l);
          end
        end
      end
      if (valid_in && ready_in) begin
        cur_words.push_back(data_in);
        if (cur_words.size() == 4 || last_in) begin
          e = '0;
          for (int k = 0; k < cur_words.size(); k++) begin
            e.d = e.d | (32'(cur_words[k]) << (8 * k));
            e.m[k] = 1'b1;
          end
          e.l = last_in;
          exp_q.push_back(e);
          cur_words.delete();
        end
      end
      prev_stall = valid_out && !ready_out;
      prev_d = data_out; prev_m = lane_valid_out; prev_l = last_out;
      step();
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: %0d packed words outstanding required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_last_partial();
    test_backpressure();
    test_clear_midway();
    test_last_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_word_packer.md
Name: pipeline_word_packer

Overview:
Upstream neighbour of the CDC word synchronizer. It packs WORD_COUNT consecutive narrow ready/valid input words into one wide ready/valid output word. The crossing then runs one multi-cycle handshake per packed word instead of one per narrow word, which amortizes the CDC round-trip cost. An optional end-of-packet marker flushes a partial word with a lane-valid mask.

Parameters:
WORD_WIDTH_IN, 8, width of each input word (>=1)
WORD_COUNT, 4, input words per output word (>=2)
(local) OUTPUT_WIDTH = WORD_WIDTH_IN*WORD_COUNT; COUNT_WIDTH = clog2(WORD_COUNT)

Ports:
clock  input  1  sole clock; all state on rising edge
clear  input  1  asynchronous, active-high reset
valid_in  input  1  input word valid
ready_in  output  1  input word accepted when valid_in & ready_in
data_in  input  WORD_WIDTH_IN  input word
last_in  input  1  marks final word of packet; qualified by valid_in & ready_in
valid_out  output  1  packed word valid
ready_out  input  1  downstream accept
data_out  output  OUTPUT_WIDTH  packed word; lane k = bits [k*WORD_WIDTH_IN +: WORD_WIDTH_IN]
lane_valid_out  output  WORD_COUNT  bit k set if lane k holds an accepted word
last_out  output  1  packed word closes a packet

Behaviour:
- Interface: one clock `clock`; `clear` is asynchronous, active-high. While clear is high, all registers are forced to reset values.
- Reset values:
  - valid_out=0, data_out=0, lane_valid_out=0, last_out=0.
  - Internal lane counter=0, assembly empty, so ready_in=1.
- State:
  - Assembly register with lanes, mask, last flag, a lane counter 0..WORD_COUNT-1, and an assembly_complete flag.
  - Output register (half-buffer style) holding data/mask/last/valid.
- Lane fill order:
  - The first accepted word goes to lane 0 (LSBs). Each accept writes lane[counter], sets mask[counter], and increments counter.
  - Unfilled lanes read as zero; lanes are zeroed whenever the assembly is handed off.
- Completion:
  - An accept into lane WORD_COUNT-1, or an accept with last_in=1, sets assembly_complete and records last.
  - The counter returns to 0.
- Handoff:
  - output_can_load = ~valid_out | ready_out.
  - On an edge where assembly_complete & output_can_load, the output register loads data/mask/last, valid_out becomes 1, and the assembly clears.
- ready_in = ~assembly_complete | output_can_load. This is a combinational path from ready_out. On a handoff cycle a new word is accepted into lane 0 of the cleared assembly, so there are no bubbles.
- Latency and throughput:
  - Final word accepted at edge N → valid_out=1 after edge N+1, given output_can_load.
  - Sustained throughput is 1 input word/cycle with ready_out=1.
- Output hold: while valid_out & ~ready_out, data_out, lane_valid_out and last_out are stable.
- Output drop: valid_out drops only after an accepted output with no pending complete assembly.
- Boundary conditions:
  - last_in on lane WORD_COUNT-1: mask all ones, last_out=1.
  - last_in on lane 0: mask 0...01.
  - last_in is ignored unless the input handshake completes.
  - Backpressure: at most one full output plus one complete assembly are held. ready_in=0 when both are full.
  - clear mid-operation: the partial assembly and pending output are discarded, and valid_out drops immediately (asynchronous). The first word after release lands in lane 0.
- Counter wraps only via completion, never by overflow.

Decomposition:
- No shared package needed. OUTPUT_WIDTH and COUNT_WIDTH are local constants.
- One natural sub-module: packer_output_register. It is a half-buffer register holding data/mask/last with valid and ready, and it takes asynchronous clear.

Test Plan:
All scenarios use WORD_WIDTH_IN=8, WORD_COUNT=4.
1. Feed 0x11,0x22,0x33,0x44, ready_out=1 → one cycle after 4th accept: data_out=0x44332211, lane_valid_out=4'b1111, last_out=0, valid_out high 1 cycle.
2. Stream 0x11..0x88 back-to-back, ready_out=1 → ready_in never low; outputs 0x44332211 then 0x88776655 on consecutive-by-4 cycles.
3. Feed 0xAA, 0xBB with last_in on 0xBB → data_out=0x0000BBAA, lane_valid_out=4'b0011, last_out=1; next word 0xCC fills lane 0 of the next output.
4. ready_out=0, feed 9 words → first output 0x44332211 held stable; after 8th accept ready_in=0; 9th stalls; raise ready_out → second output 0x88776655 presented, 9th accepted same cycle.
5. Accept 0x11,0x22, pulse clear (between clock edges) → valid_out=0 and ready_in=1 immediately; then feed 0x55..0x88 → data_out=0x88776655, mask 1111, no stale lanes.
6. last_in=1 with valid_in=0 for several cycles → no effect. Then 4 words with last_in on the 4th → mask 4'b1111, last_out=1.
